nxn_game_engine: RTL and testbench
==================================

Name: nxn_game_engine

Overview:
- Sequential game engine for a generalised N x N "mark-a-line" board game, two players X and O.
- Owns the board state, turn alternation, move handshake, illegal-move rejection, win/draw detection and game-over lock.
- Sits between the player-input front end (keypad/decoder) and the display driver.
- Replaces the fixed 3x3, always-X, FSM-less board path.

Parameters:
- N, 3, board side length; legal range 3..8; board has N*N cells.
- POS_W, $clog2(N*N) (min 1), width of the move-position index.
- CNT_W, $clog2(N*N+1), width of the move counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears the entire game.
- new_game  input  1  synchronous; same effect as reset, applied one cycle after assertion. reset has priority.
- first_o  input  1  sampled on reset/new_game only; 1 = O moves first, 0 = X moves first.
- move_valid  input  1  move request strobe.
- move_pos  input  POS_W  cell index, row-major; index = row*N + col.
- move_ready  output  1  engine accepts a move this cycle.
- board  output  2*N*N  cell k occupies bits [2k+1:2k]; 00 empty, 01 X, 10 O; 11 is never produced.
- turn  output  2  player to move: 01 X, 10 O; 00 when game over.
- illegal  output  1  one-cycle pulse when a presented move is rejected.
- win  output  1  level; held high while in OVER with a winner.
- who  output  2  winner: 01 X, 10 O; 00 for no winner or draw.
- draw  output  1  level; board full and no winner.
- move_count  output  CNT_W  number of accepted moves.

Behaviour:
- Reset values (reset or new_game): board=0, move_count=0, win=0, draw=0, who=00, illegal=0, state=WAIT.
  - turn = 10 if first_o, else 01. move_ready = 1.
- States:
  - WAIT: move_ready=1.
  - CHECK: move_ready=0, one cycle.
  - OVER: move_ready=0; board, win, who and draw frozen.
- Handshake: a move is presented when move_valid && move_ready. Position is legal iff move_pos < N*N and the addressed cell is 00.
- Legal move in WAIT at cycle t:
  - At t+1: cell = turn code, move_count += 1, state = CHECK.
  - At t+2: evaluation of the updated board is registered.
    - Win: win=1, who=the mover, turn=00, state=OVER.
    - Else if move_count == N*N: draw=1, turn=00, state=OVER.
    - Else: turn toggles 01<->10, state=WAIT.
  - Move-to-result latency is 2 cycles. Maximum move rate is one per 2 cycles.
- Illegal move in WAIT (out of range or occupied): illegal=1 at t+1 for exactly one cycle. No board write, no count change, turn unchanged, stays in WAIT.
- move_valid in CHECK or OVER is ignored: no illegal pulse, no state change.
- Win rule: any complete row, column, main diagonal or anti-diagonal of N equal non-empty cells. There are 2N+2 lines.
  - Only the mover can complete a line, so who = the mover's code.
- Win on the final cell: win takes priority, draw=0.
- new_game asserted in CHECK mid-evaluation: the reset takes effect and the pending evaluation is discarded.
- move_count never wraps, since it saturates at N*N by construction.
- All outputs are registered except move_ready, which is a decode of state.

Decomposition:
- Package nxn_game_pkg:
  - Cell codes: CELL_EMPTY=2'b00, CELL_X=2'b01, CELL_O=2'b10.
  - State enum: WAIT, CHECK, OVER.
  - Function: line-count helper 2N+2.
- One sub-module nxn_win_detector: purely combinational over the board vector.
  - Parameterised by N.
  - Outputs win_any and win_code (2 bits) across all 2N+2 lines, built with generate loops.
- The engine instantiates this detector and registers its outputs in CHECK.

Test Plan:
1. N=3, first_o=0; X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 -> two cycles after the last move: win=1, who=01, turn=00, board[5:0]=010101, move_ready=0.
2. N=3; X plays 4, then O presents move_pos=4 -> illegal pulses one cycle, board unchanged, turn stays 10, move_count=1. Then O presents move_pos=9 -> illegal pulses again.
3. N=3, X first; sequence 0,1,2,4,3,5,7,6,8 -> after the 9th move: draw=1, win=0, who=00, move_count=9.
4. N=4, first_o=1; O plays 3,6,9,12 (anti-diagonal) interleaved with X plays 0,1,2 -> win=1, who=10 two cycles after O's 4th move.
5. Game over in case 1; drive move_valid with move_pos=8 -> no change, illegal=0. Pulse new_game -> next cycle board=0, turn=01, move_ready=1.
6. Present a legal move, then assert reset on the CHECK cycle -> next cycle: board=0, move_count=0, win=0, state=WAIT; back-to-back move_valid during CHECK is not accepted.

Source files
------------

// File: rtl/nxn_game_pkg.sv
// Shared cell codes, engine states and board-geometry helpers for the N x N game engine.
package nxn_game_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [1:0] {
        WAIT  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    function automatic int line_count(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int pos_width(input int n);
        return ($clog2(n * n) < 1) ? 1 : $clog2(n * n);
    endfunction

    // Lines are numbered rows first, then columns, then the main diagonal, then the anti-diagonal.
    function automatic int line_cell(input int n, input int l, input int i);
        if (l < n)
            return l * n + i;
        else if (l < 2 * n)
            return i * n + (l - n);
        else if (l == 2 * n)
            return i * (n + 1);
        else
            return i * n + (n - 1 - i);
    endfunction

endpackage

// File: rtl/nxn_game_engine_if.sv
// Move handshake between the player-input front end (master) and the game engine (slave).
interface nxn_game_engine_if
    import nxn_game_pkg::*;
#(
    parameter int N = 3
);
    localparam int POS_W = pos_width(N);

    logic             move_valid;
    logic [POS_W-1:0] move_pos;
    logic             move_ready;
    logic             illegal;

    modport master (output move_valid, output move_pos, input move_ready, input illegal);
    modport slave  (input move_valid, input move_pos, output move_ready, output illegal);

endinterface

// File: rtl/nxn_win_detector.sv
// Combinational scan of all 2N+2 lines; reports whether any line is complete and whose it is.
module nxn_win_detector
    import nxn_game_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [2*N*N-1:0] board,
    output logic             win_any,
    output logic [1:0]       win_code
);
    localparam int LINES = line_count(N);

    logic [LINES-1:0] x_line;
    logic [LINES-1:0] o_line;

    for (genvar l = 0; l < LINES; l++) begin : g_line
        localparam int HEAD = line_cell(N, l, 0);
        logic [N-1:0] same;

        for (genvar i = 0; i < N; i++) begin : g_cell
            localparam int IDX = line_cell(N, l, i);
            assign same[i] = (board[2*IDX +: 2] == board[2*HEAD +: 2]);
        end

        assign x_line[l] = (&same) && (board[2*HEAD +: 2] == CELL_X);
        assign o_line[l] = (&same) && (board[2*HEAD +: 2] == CELL_O);
    end

    // Only the player who just moved can own a complete line, so the two flags never both set.
    assign win_any  = (|x_line) || (|o_line);
    assign win_code = {|o_line, |x_line};

endmodule

// File: rtl/nxn_game_engine.sv
// Game engine: owns the board, alternates turns, rejects illegal moves and locks on a win or draw.
module nxn_game_engine
    import nxn_game_pkg::*;
#(
    parameter int N     = 3,
    parameter int POS_W = pos_width(N),
    parameter int CNT_W = $clog2(N * N + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 first_o,
    nxn_game_engine_if.slave     mv,
    output logic [2*N*N-1:0]     board,
    output logic [1:0]           turn,
    output logic                 win,
    output logic [1:0]           who,
    output logic                 draw,
    output logic [CNT_W-1:0]     move_count
);
    localparam int CELLS = N * N;

    state_t             state;
    state_t             state_next;
    logic [CELLS-1:0]   target;
    logic [2*CELLS-1:0] board_written;
    logic               legal;
    logic               det_win;
    logic [1:0]         det_code;
    logic               board_full;

    // An out-of-range position matches no cell, so it falls out as illegal with no extra compare.
    for (genvar k = 0; k < CELLS; k++) begin : g_cell
        assign target[k] = (mv.move_pos == POS_W'(k)) && (board[2*k +: 2] == CELL_EMPTY);
        assign board_written[2*k +: 2] = target[k] ? turn : board[2*k +: 2];
    end

    assign legal      = |target;
    assign board_full = (move_count == CNT_W'(CELLS));

    nxn_win_detector #(.N(N)) u_win_detector (
        .board    (board),
        .win_any  (det_win),
        .win_code (det_code)
    );

    always_ff @(posedge clock) begin
        if (reset || new_game)
            state <= WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        mv.move_ready = 1'b0;
        case (state)
            WAIT: begin
                mv.move_ready = 1'b1;
                if (mv.move_valid && legal)
                    state_next = CHECK;
            end
            CHECK:   state_next = (det_win || board_full) ? OVER : WAIT;
            OVER:    state_next = OVER;
            default: state_next = WAIT;
        endcase
    end

    // CHECK sees the board already holding the new mark, and turn still names the mover.
    always_ff @(posedge clock) begin
        if (reset || new_game) begin
            board      <= '0;
            turn       <= first_o ? CELL_O : CELL_X;
            move_count <= '0;
            mv.illegal <= 1'b0;
            win        <= 1'b0;
            who        <= CELL_EMPTY;
            draw       <= 1'b0;
        end else begin
            mv.illegal <= 1'b0;
            case (state)
                WAIT: begin
                    if (mv.move_valid) begin
                        if (legal) begin
                            board      <= board_written;
                            move_count <= move_count + CNT_W'(1);
                        end else begin
                            mv.illegal <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (det_win) begin
                        win  <= 1'b1;
                        who  <= det_code;
                        turn <= CELL_EMPTY;
                    end else if (board_full) begin
                        draw <= 1'b1;
                        turn <= CELL_EMPTY;
                    end else begin
                        turn <= (turn == CELL_X) ? CELL_O : CELL_X;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nxn_game_engine.sv
// Bench for nxn_game_engine: an N=3 and an N=4 engine, each tracked every cycle by a cell-array
// reference model, plus directed games with hand-computed expectations.
`timescale 1ns/1ps
module tb_nxn_game_engine;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       new_game   = 1'b0;
    logic       first_o    = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos   = '0;
    int         active     = 0;
    bit         check_en   = 1'b0;
    int         errors     = 0;
    int         checks     = 0;

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int N     = 3 + g;
        localparam int CELLS = N * N;
        localparam int CNT_W = $clog2(CELLS + 1);

        nxn_game_engine_if #(.N(N)) mv_if ();

        logic [2*CELLS-1:0] board;
        logic [1:0]         turn;
        logic               win;
        logic [1:0]         who;
        logic               draw;
        logic [CNT_W-1:0]   move_count;

        assign mv_if.move_valid = move_valid && (active == g);
        assign mv_if.move_pos   = move_pos;

        nxn_game_engine #(.N(N)) dut (
            .clock      (clock),
            .reset      (reset),
            .new_game   (new_game),
            .first_o    (first_o),
            .mv         (mv_if),
            .board      (board),
            .turn       (turn),
            .win        (win),
            .who        (who),
            .draw       (draw),
            .move_count (move_count)
        );

        // Reference: cells hold 0 empty, 1 X, 2 O; a result is owed the cycle after each accepted move.
        int mb [64];
        int m_turn, m_count, m_illegal, m_win, m_who, m_draw;
        bit m_due, m_over;

        function automatic bit won(input int p);
            bit hit;
            bit any;
            any = 1'b0;
            for (int r = 0; r < N; r++) begin
                hit = 1'b1;
                for (int c = 0; c < N; c++) if (mb[r*N + c] != p) hit = 1'b0;
                if (hit) any = 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                hit = 1'b1;
                for (int r = 0; r < N; r++) if (mb[r*N + c] != p) hit = 1'b0;
                if (hit) any = 1'b1;
            end
            hit = 1'b1;
            for (int i = 0; i < N; i++) if (mb[i*N + i] != p) hit = 1'b0;
            if (hit) any = 1'b1;
            hit = 1'b1;
            for (int i = 0; i < N; i++) if (mb[i*N + (N - 1 - i)] != p) hit = 1'b0;
            if (hit) any = 1'b1;
            return any;
        endfunction

        function automatic logic [63:0] model_board();
            logic [63:0] v;
            v = '0;
            for (int k = 0; k < CELLS; k++) v[2*k +: 2] = 2'(mb[k]);
            return v;
        endfunction

        always @(posedge clock) begin
            if (reset || new_game) begin
                for (int k = 0; k < 64; k++) mb[k] = 0;
                m_turn    = first_o ? 2 : 1;
                m_count   = 0;
                m_illegal = 0;
                m_win     = 0;
                m_who     = 0;
                m_draw    = 0;
                m_due     = 1'b0;
                m_over    = 1'b0;
            end else begin
                m_illegal = 0;
                if (m_due) begin
                    m_due = 1'b0;
                    if (won(m_turn)) begin
                        m_win  = 1;
                        m_who  = m_turn;
                        m_turn = 0;
                        m_over = 1'b1;
                    end else if (m_count == CELLS) begin
                        m_draw = 1;
                        m_turn = 0;
                        m_over = 1'b1;
                    end else begin
                        m_turn = 3 - m_turn;
                    end
                end else if (!m_over && mv_if.move_valid) begin
                    if (int'(mv_if.move_pos) < CELLS && mb[mv_if.move_pos] == 0) begin
                        mb[mv_if.move_pos] = m_turn;
                        m_count++;
                        m_due = 1'b1;
                    end else begin
                        m_illegal = 1;
                    end
                end
            end
        end

        always @(negedge clock) begin
            if (check_en) begin
                check_output($sformatf("N%0d move_ready", N), 64'(mv_if.move_ready), 64'(!(m_due || m_over)));
                check_output($sformatf("N%0d board", N), 64'(board), model_board());
                check_output($sformatf("N%0d turn", N), 64'(turn), 64'(m_turn));
                check_output($sformatf("N%0d illegal", N), 64'(mv_if.illegal), 64'(m_illegal));
                check_output($sformatf("N%0d win", N), 64'(win), 64'(m_win));
                check_output($sformatf("N%0d who", N), 64'(who), 64'(m_who));
                check_output($sformatf("N%0d draw", N), 64'(draw), 64'(m_draw));
                check_output($sformatf("N%0d move_count", N), 64'(move_count), 64'(m_count));
            end
        end
    end

    // One accepted move spans two cycles: the strobe cycle and the evaluation cycle.
    task automatic play_move(input int inst, input int pos);
        active     = inst;
        move_valid = 1'b1;
        move_pos   = 4'(pos);
        @(negedge clock);
        move_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic present_move(input int inst, input int pos);
        active     = inst;
        move_valid = 1'b1;
        move_pos   = 4'(pos);
        @(negedge clock);
        move_valid = 1'b0;
    endtask

    task automatic apply_stimulus_restart(input bit o_first);
        first_o  = o_first;
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
    endtask

    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int anti_seq [7] = '{3, 0, 6, 1, 9, 2, 12};

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        check_en = 1'b1;
        check_output("reset board", 64'(g_inst[0].board), 64'd0);
        check_output("reset turn", 64'(g_inst[0].turn), 64'h1);
        check_output("reset ready", 64'(g_inst[0].mv_if.move_ready), 64'd1);
        check_output("reset count", 64'(g_inst[0].move_count), 64'd0);
        check_output("reset model turn", 64'(g_inst[0].m_turn), 64'd1);

        // Row 0 win for X.
        play_move(0, 0); play_move(0, 3); play_move(0, 1); play_move(0, 4); play_move(0, 2);
        check_output("row win", 64'(g_inst[0].win), 64'd1);
        check_output("row who", 64'(g_inst[0].who), 64'h1);
        check_output("row turn", 64'(g_inst[0].turn), 64'h0);
        check_output("row board low", 64'(g_inst[0].board[5:0]), 64'b010101);
        check_output("row ready", 64'(g_inst[0].mv_if.move_ready), 64'd0);
        check_output("row model who", 64'(g_inst[0].m_who), 64'd1);

        // Moves after game over are ignored, then new_game clears.
        present_move(0, 8);
        check_output("over illegal", 64'(g_inst[0].mv_if.illegal), 64'd0);
        check_output("over board", 64'(g_inst[0].board), 64'h295);
        apply_stimulus_restart(1'b0);
        check_output("new board", 64'(g_inst[0].board), 64'd0);
        check_output("new turn", 64'(g_inst[0].turn), 64'h1);
        check_output("new ready", 64'(g_inst[0].mv_if.move_ready), 64'd1);

        // Occupied cell, then out-of-range cell.
        play_move(0, 4);
        present_move(0, 4);
        check_output("occupied illegal", 64'(g_inst[0].mv_if.illegal), 64'd1);
        check_output("occupied board", 64'(g_inst[0].board), 64'h100);
        check_output("occupied turn", 64'(g_inst[0].turn), 64'h2);
        check_output("occupied count", 64'(g_inst[0].move_count), 64'd1);
        @(negedge clock);
        check_output("illegal one cycle", 64'(g_inst[0].mv_if.illegal), 64'd0);
        present_move(0, 9);
        check_output("range illegal", 64'(g_inst[0].mv_if.illegal), 64'd1);
        check_output("range board", 64'(g_inst[0].board), 64'h100);
        @(negedge clock);

        // Full board with no line.
        apply_stimulus_restart(1'b0);
        foreach (draw_seq[i]) play_move(0, draw_seq[i]);
        check_output("draw flag", 64'(g_inst[0].draw), 64'd1);
        check_output("draw win", 64'(g_inst[0].win), 64'd0);
        check_output("draw who", 64'(g_inst[0].who), 64'h0);
        check_output("draw count", 64'(g_inst[0].move_count), 64'd9);
        check_output("draw model", 64'(g_inst[0].m_draw), 64'd1);

        // N=4 anti-diagonal win for O moving first.
        apply_stimulus_restart(1'b1);
        check_output("n4 first turn", 64'(g_inst[1].turn), 64'h2);
        foreach (anti_seq[i]) play_move(1, anti_seq[i]);
        check_output("anti win", 64'(g_inst[1].win), 64'd1);
        check_output("anti who", 64'(g_inst[1].who), 64'h2);
        check_output("anti count", 64'(g_inst[1].move_count), 64'd7);
        check_output("anti model who", 64'(g_inst[1].m_who), 64'd2);

        // A strobe held into the evaluation cycle is not taken as a second move.
        apply_stimulus_restart(1'b0);
        present_move(0, 0);
        move_valid = 1'b1;
        move_pos   = 4'd1;
        @(negedge clock);
        move_valid = 1'b0;
        check_output("held count", 64'(g_inst[0].move_count), 64'd1);
        check_output("held board", 64'(g_inst[0].board), 64'h1);
        check_output("held illegal", 64'(g_inst[0].mv_if.illegal), 64'd0);

        // Reset landing in the evaluation cycle discards the pending result.
        present_move(0, 5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_output("mid reset board", 64'(g_inst[0].board), 64'd0);
        check_output("mid reset count", 64'(g_inst[0].move_count), 64'd0);
        check_output("mid reset win", 64'(g_inst[0].win), 64'd0);
        check_output("mid reset ready", 64'(g_inst[0].mv_if.move_ready), 64'd1);
        check_output("mid reset turn", 64'(g_inst[0].turn), 64'h1);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
